// File: rtl/fft_stage_ctrl_if.sv
// Control bundle between the FFT sequencer and its surroundings: input/output
// stream handshakes plus the butterfly/RAM addressing the sequencer drives.
interface fft_stage_ctrl_if #(
  parameter int LOG2N = 8
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [LOG2N-1:0] load_addr;
  logic             bf_en;
  logic [LOG2N-1:0] bf_addr_a;
  logic [LOG2N-1:0] bf_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [2:0]       stage;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] unload_addr;
  logic             busy;
  logic             done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, load_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx,
           stage, out_valid, unload_addr, busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, load_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx,
           stage, out_valid, unload_addr, busy, done
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Frame sequencer for an in-place radix-2 DIF FFT: sample load, LOG2N butterfly
// stages separated by a write-back drain, then bit-reversed readout.
module fft_stage_ctrl #(
  parameter int LOG2N    = 8,
  parameter int BFLY_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_stage_ctrl_if.master bus
);

  localparam int N  = 1 << LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF       = LOG2N'(N / 2);
  localparam logic [KW-1:0]    K_LAST     = KW'(N / 2 - 1);
  localparam logic [DW-1:0]    D_LAST     = DW'(BFLY_LAT - 1);
  localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CALC   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q,   cnt_d;
  logic [KW-1:0]    k_q,     k_d;
  logic [2:0]       stage_q, stage_d;
  logic [DW-1:0]    dcnt_q,  dcnt_d;
  logic             done_q,  done_d;

  // Distance between the two legs of a butterfly in the given stage.
  function automatic logic [LOG2N-1:0] span_of(input logic [2:0] stg);
    return HALF >> stg;
  endfunction

  // Upper-leg address: butterfly index k with a zero spliced in at the span bit.
  function automatic logic [LOG2N-1:0] insert_zero(input logic [KW-1:0] k,
                                                   input logic [2:0]    stg);
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] lo;
    kx = {1'b0, k};
    lo = span_of(stg) - LOG2N'(1);
    return ((kx & ~lo) << 1) | (kx & lo);
  endfunction

  function automatic logic [KW-1:0] twiddle(input logic [KW-1:0] k,
                                            input logic [2:0]    stg);
    logic [KW-1:0] lo_k;
    lo_k = KW'(span_of(stg) - LOG2N'(1));
    return (k & lo_k) << stg;
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_CALC;
            cnt_d   = '0;
            k_d     = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      S_CALC: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // Hold off the next stage until the last write-backs have landed.
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
            cnt_d   = '0;
          end else begin
            state_d = S_CALC;
            stage_d = stage_q + 3'd1;
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_UNLOAD: begin
        if (bus.out_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded from registered state so they are stable for the whole cycle.
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.load_addr   = '0;
    bus.bf_en       = 1'b0;
    bus.bf_addr_a   = '0;
    bus.bf_addr_b   = '0;
    bus.tw_idx      = '0;
    bus.out_valid   = 1'b0;
    bus.unload_addr = '0;
    bus.stage       = stage_q;
    bus.busy        = (state_q != S_IDLE);
    bus.done        = done_q;
    case (state_q)
      S_LOAD: begin
        bus.in_ready  = 1'b1;
        bus.load_addr = cnt_q;
      end
      S_CALC: begin
        bus.bf_en     = 1'b1;
        bus.bf_addr_a = insert_zero(k_q, stage_q);
        bus.bf_addr_b = insert_zero(k_q, stage_q) | span_of(stage_q);
        bus.tw_idx    = twiddle(k_q, stage_q);
      end
      S_UNLOAD: begin
        bus.out_valid   = 1'b1;
        bus.unload_addr = bitrev(cnt_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: a scoreboard of expected load/butterfly/unload
// addresses per frame, a table of spot-checked butterflies, and corner sequences.
module tb_fft_stage_ctrl;

  localparam int LOG2N     = 8;
  localparam int BFLY_LAT  = 4;
  localparam int N         = 1 << LOG2N;
  localparam int FRAME_CYC = N + LOG2N * (N / 2 + BFLY_LAT) + N;

  typedef struct {
    int stage;
    int a;
    int b;
    int tw;
  } bf_t;

  typedef struct {
    int stage;
    int k;
    int a;
    int b;
    int tw;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_stage_ctrl_if #(.LOG2N(LOG2N)) bus ();

  fft_stage_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(BFLY_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  done_cnt = 0;
  int  bf_cnt = 0;
  int  drain_len = 0;
  int  last_stage = 0;
  int  un_hs = 0;
  int  stall_seen = 0;
  int  stall_left = 0;
  bit  stall_en = 0;
  bit  iv_mode = 0;
  bit  len_chk = 1;

  int  load_q[$];
  int  unl_q[$];
  bf_t bf_q[$];

  vec_t tbl[6];
  bit   tbl_hit[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_underflow(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced %0d with no expected entry (cycle %0d)", name, act, cyc);
  endtask

  // Expected traffic of one whole frame, built group-by-group rather than from k.
  task automatic push_frame();
    bf_t e;
    int  span, r, x;
    for (int i = 0; i < N; i++) load_q.push_back(i);
    for (int s = 0; s < LOG2N; s++) begin
      span = N >> (s + 1);
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int j = 0; j < span; j++) begin
          e.stage = s;
          e.a     = g * 2 * span + j;
          e.b     = e.a + span;
          e.tw    = (j << s) % (N / 2);
          bf_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      r = 0;
      x = i;
      for (int bt = 0; bt < LOG2N; bt++) begin
        r = r * 2 + (x % 2);
        x = x / 2;
      end
      unl_q.push_back(r);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},    int'(bus.in_ready), 0);
    chk({tag, "_load_addr"},   int'(bus.load_addr), 0);
    chk({tag, "_bf_en"},       int'(bus.bf_en), 0);
    chk({tag, "_bf_addr_a"},   int'(bus.bf_addr_a), 0);
    chk({tag, "_bf_addr_b"},   int'(bus.bf_addr_b), 0);
    chk({tag, "_tw_idx"},      int'(bus.tw_idx), 0);
    chk({tag, "_stage"},       int'(bus.stage), 0);
    chk({tag, "_out_valid"},   int'(bus.out_valid), 0);
    chk({tag, "_unload_addr"}, int'(bus.unload_addr), 0);
    chk({tag, "_busy"},        int'(bus.busy), 0);
    chk({tag, "_done"},        int'(bus.done), 0);
  endtask

  // which: 0 out_valid, 1 done, 2 CALC in stage 2, 3 CALC in stage 3
  task automatic wait_for(input int which, input int limit, input string name);
    bit ok;
    bit hit;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = bus.out_valid;
        1:       hit = bus.done;
        2:       hit = bus.bf_en && (bus.stage == 3'd2);
        default: hit = bus.bf_en && (bus.stage == 3'd3);
      endcase
      if (hit) begin
        ok = 1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.in_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.in_valid = iv_mode ? ~bus.in_valid : 1'b1;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && un_hs == 10 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Scoreboard / protocol monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        done_cnt++;
        chk("done_not_busy", int'(bus.busy), 0);
        chk("sb_left", load_q.size() + bf_q.size() + unl_q.size(), 0);
        if (len_chk) chk("frame_len", cyc - start_cyc, FRAME_CYC);
      end
      if (bus.start && !bus.busy) begin
        start_cyc = cyc + 1;
        un_hs     = 0;
        push_frame();
      end
      if (bus.in_ready) begin
        if (bus.in_valid) begin
          if (load_q.size() > 0) chk("load_addr", int'(bus.load_addr), load_q.pop_front());
          else sb_underflow("load_addr", int'(bus.load_addr));
        end else if (load_q.size() > 0) begin
          chk("load_hold", int'(bus.load_addr), load_q[0]);
        end
      end
      if (bus.bf_en) begin
        bf_t e;
        if (drain_len > 0) begin
          chk("drain_len", drain_len, BFLY_LAT);
          drain_len = 0;
        end
        for (int i = 0; i < 6; i++) begin
          if (tbl[i].stage == int'(bus.stage) && tbl[i].k == bf_cnt) begin
            tbl_hit[i] = 1'b1;
            chk($sformatf("tbl%0d_a", i),  int'(bus.bf_addr_a), tbl[i].a);
            chk($sformatf("tbl%0d_b", i),  int'(bus.bf_addr_b), tbl[i].b);
            chk($sformatf("tbl%0d_tw", i), int'(bus.tw_idx),    tbl[i].tw);
          end
        end
        if (bf_q.size() > 0) begin
          e = bf_q.pop_front();
          chk("bf_stage", int'(bus.stage),     e.stage);
          chk("bf_addr_a", int'(bus.bf_addr_a), e.a);
          chk("bf_addr_b", int'(bus.bf_addr_b), e.b);
          chk("tw_idx",    int'(bus.tw_idx),    e.tw);
        end else begin
          sb_underflow("bf_addr_a", int'(bus.bf_addr_a));
        end
        last_stage = int'(bus.stage);
        bf_cnt++;
      end else if (bus.busy && !bus.in_ready && !bus.out_valid) begin
        if (drain_len == 0) begin
          chk("stage_len", bf_cnt, N / 2);
          bf_cnt = 0;
        end
        chk("drain_stage", int'(bus.stage), last_stage);
        drain_len++;
      end
      if (bus.out_valid) begin
        if (drain_len > 0) begin
          chk("drain_len", drain_len, BFLY_LAT);
          drain_len = 0;
        end
        if (bus.out_ready) begin
          if (unl_q.size() > 0) chk("unload_addr", int'(bus.unload_addr), unl_q.pop_front());
          else sb_underflow("unload_addr", int'(bus.unload_addr));
          un_hs++;
        end else begin
          stall_seen++;
          if (unl_q.size() > 0) chk("unload_hold", int'(bus.unload_addr), unl_q[0]);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{stage: 0, k: 0,   a: 0,   b: 128, tw: 0};
    tbl[1] = '{stage: 0, k: 5,   a: 5,   b: 133, tw: 5};
    tbl[2] = '{stage: 0, k: 127, a: 127, b: 255, tw: 127};
    tbl[3] = '{stage: 1, k: 65,  a: 129, b: 193, tw: 2};
    tbl[4] = '{stage: 3, k: 20,  a: 36,  b: 52,  tw: 32};
    tbl[5] = '{stage: 7, k: 3,   a: 6,   b: 7,   tw: 0};
    for (int i = 0; i < 6; i++) tbl_hit[i] = 1'b0;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ignores_in_valid", int'(bus.in_ready), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Frame 1: no stalls, then hold start so it lands in the done cycle.
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("load_in_ready", int'(bus.in_ready), 1);
    chk("load_busy", int'(bus.busy), 1);
    wait_for(0, 3000, "wait_unload1");
    @(posedge clk);
    #1 bus.start = 1'b1;
    wait_for(1, 600, "wait_done1");
    #1;
    chk("done_count1", done_cnt, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("tbl%0d_seen", i), int'(tbl_hit[i]), 1);
    iv_mode    = 1'b1;
    stall_en   = 1'b1;
    stall_left = 3;
    len_chk    = 1'b0;
    stall_seen = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("restart_in_ready", int'(bus.in_ready), 1);
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_done_low", int'(bus.done), 0);

    // Frame 2: toggling in_valid, a start pulse mid-CALC, a 3-cycle output stall.
    wait_for(2, 2000, "wait_stage2");
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("calc_start_ignored_bf_en", int'(bus.bf_en), 1);
    chk("calc_start_ignored_in_ready", int'(bus.in_ready), 0);
    wait_for(1, 4000, "wait_done2");
    #1;
    chk("done_count2", done_cnt, 2);
    chk("stall_cycles", stall_seen, 3);
    iv_mode  = 1'b0;
    stall_en = 1'b0;

    // Frame 3: asynchronous reset in the middle of stage 3.
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_for(3, 2000, "wait_stage3");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    load_q.delete();
    bf_q.delete();
    unl_q.delete();
    bf_cnt    = 0;
    drain_len = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_bf_en", int'(bus.bf_en), 0);
    chk("post_reset_done_count", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
